// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment checks, one SRAM-like
// req/addr_ok/data_ok transaction at a time, load formatting and store strobes.
module dmem_access_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_en,
   input  logic [7:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        flush,
   input  logic        pipe_go,
   output logic        mem_stall,
   output logic [31:0] load_data,
   output logic        adel,
   output logic        ades,
   output logic [31:0] bad_addr,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   logic        r_cancel;
   logic [7:0]  r_op;
   logic [1:0]  r_off;

   logic        w_load, w_store, w_misal, w_idle, w_start;
   logic [1:0]  w_size;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata, w_ldata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_load  = 1'b0;
      w_store = 1'b0;
      w_size  = 2'd0;
      w_wstrb = 4'b0000;
      w_wdata = mem_wdata;
      case (mem_op)
         EXE_LB_OP, EXE_LBU_OP: w_load = 1'b1;
         EXE_LH_OP, EXE_LHU_OP: begin w_load = 1'b1; w_size = 2'd1; end
         EXE_LW_OP:             begin w_load = 1'b1; w_size = 2'd2; end
         EXE_SB_OP: begin
            w_store = 1'b1;
            w_wstrb = 4'b0001 << mem_addr[1:0];
            w_wdata = {4{mem_wdata[7:0]}};
         end
         EXE_SH_OP: begin
            w_store = 1'b1;
            w_size  = 2'd1;
            w_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_wdata[15:0]}};
         end
         EXE_SW_OP: begin
            w_store = 1'b1;
            w_size  = 2'd2;
            w_wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   assign w_misal   = ((w_size == 2'd1) & mem_addr[0]) | ((w_size == 2'd2) & (|mem_addr[1:0]));
   assign w_idle    = (r_state == S_IDLE);
   assign adel      = w_idle & mem_en & w_load  & w_misal;
   assign ades      = w_idle & mem_en & w_store & w_misal;
   assign bad_addr  = mem_en ? mem_addr : 32'd0;
   assign w_start   = w_idle & mem_en & (w_load | w_store) & ~w_misal & ~flush;
   assign mem_stall = w_start | (r_state == S_REQ) | (r_state == S_WAIT);

   // Lane selection uses the offset captured at request time, not the live address.
   always_comb begin
      case (r_off)
         2'd0:    w_byte = data_rdata[7:0];
         2'd1:    w_byte = data_rdata[15:8];
         2'd2:    w_byte = data_rdata[23:16];
         default: w_byte = data_rdata[31:24];
      endcase
      w_half = r_off[1] ? data_rdata[31:16] : data_rdata[15:0];
      case (r_op)
         EXE_LB_OP:  w_ldata = {{24{w_byte[7]}}, w_byte};
         EXE_LBU_OP: w_ldata = {24'd0, w_byte};
         EXE_LH_OP:  w_ldata = {{16{w_half[15]}}, w_half};
         EXE_LHU_OP: w_ldata = {16'd0, w_half};
         default:    w_ldata = data_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cancel   <= 1'b0;
         r_op       <= 8'd0;
         r_off      <= 2'd0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= 2'd0;
         data_addr  <= 32'd0;
         data_wdata <= 32'd0;
         data_wstrb <= 4'd0;
         load_data  <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state    <= S_REQ;
               r_cancel   <= 1'b0;
               r_op       <= mem_op;
               r_off      <= mem_addr[1:0];
               data_req   <= 1'b1;
               data_wr    <= w_store;
               data_size  <= w_size;
               data_addr  <= mem_addr;
               data_wdata <= w_wdata;
               data_wstrb <= w_wstrb;
            end
            S_REQ: begin
               if (flush) r_cancel <= 1'b1;
               if (data_addr_ok) begin
                  data_req <= 1'b0;
                  r_state  <= S_WAIT;
               end
            end
            // A flushed access still completes on the bus; only its result is dropped.
            S_WAIT: begin
               if (data_data_ok) begin
                  r_cancel <= 1'b0;
                  if (r_cancel | flush) r_state <= S_IDLE;
                  else begin
                     load_data <= w_ldata;
                     r_state   <= S_DONE;
                  end
               end else if (flush) r_cancel <= 1'b1;
            end
            default: if (pipe_go | flush) r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed table, flush sequences and randomized
// accesses checked against an arithmetic reference model.
module tb_dmem_access_ctrl;

   localparam logic [7:0] OP_LB  = 8'b1110_0000;
   localparam logic [7:0] OP_LBU = 8'b1110_0100;
   localparam logic [7:0] OP_LH  = 8'b1110_0001;
   localparam logic [7:0] OP_LHU = 8'b1110_0101;
   localparam logic [7:0] OP_LW  = 8'b1110_0011;
   localparam logic [7:0] OP_SB  = 8'b1110_1000;
   localparam logic [7:0] OP_SH  = 8'b1110_1001;
   localparam logic [7:0] OP_SW  = 8'b1110_1011;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        mem_en = 1'b0, flush = 1'b0, pipe_go = 1'b0;
   logic [7:0]  mem_op = 8'd0;
   logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
   logic        mem_stall, adel, ades, data_req, data_wr;
   logic [31:0] load_data, bad_addr, data_addr, data_wdata;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = 32'd0;

   dmem_access_ctrl dut (
      .clk(clk), .resetn(resetn), .mem_en(mem_en), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush), .pipe_go(pipe_go),
      .mem_stall(mem_stall), .load_data(load_data), .adel(adel), .ades(ades),
      .bad_addr(bad_addr), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr, wdata, rdata;
      int          aok, dok, hold;
      logic        exp_adel, exp_ades;
      logic [31:0] exp_load;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
   } vec_t;

   int          n_vec = 0, n_err = 0;
   logic [31:0] last_ld = 32'd0;
   vec_t        tbl [10];
   logic [7:0]  ops [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [7:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic bit is_load(input logic [7:0] op);
      return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
   endfunction

   // Reference model: access width n, lane = (addr%4)/n, plain shifts/masks.
   function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int aok, input int dok, input int hold);
      vec_t   v;
      int     n, lane;
      longint mask, raw, rep;
      n    = nbytes(op);
      lane = int'(addr % 4) / n;
      mask = (64'd1 << (8 * n)) - 1;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.aok = aok; v.dok = dok; v.hold = hold;
      v.exp_adel = is_load(op) && (addr % n != 0);
      v.exp_ades = !is_load(op) && (addr % n != 0);
      raw = (longint'(rdata) >> (8 * n * lane)) & mask;
      if ((op == OP_LB || op == OP_LH) && raw >= (longint'(1) << (8 * n - 1)))
         raw = raw - (longint'(1) << (8 * n));
      v.exp_load = raw[31:0];
      rep = 0;
      for (int k = 0; k < 4 / n; k++) rep = rep | ((longint'(wdata) & mask) << (8 * n * k));
      v.exp_wdata = rep[31:0];
      v.exp_wstrb = is_load(op) ? 4'd0 : 4'(((1 << n) - 1) << (n * lane));
      return v;
   endfunction

   // One access from IDLE (C0) through DONE and back to IDLE via pipe_go.
   task automatic do_access(input vec_t v);
      int n;
      n = nbytes(v.op);
      mem_en = 1'b1; mem_op = v.op; mem_addr = v.addr; mem_wdata = v.wdata;
      pipe_go = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("adel", adel, v.exp_adel);
      chk("ades", ades, v.exp_ades);
      if (v.exp_adel || v.exp_ades) begin
         chk("bad_addr", bad_addr, v.addr);
         chk("fault_stall", mem_stall, 0);
         chk("fault_req", data_req, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("fault_req_next", data_req, 0);
         @(posedge clk); #1;
         mem_en = 1'b0;
         return;
      end
      chk("c0_stall", mem_stall, 1);
      chk("c0_req", data_req, 0);
      @(posedge clk); #1;
      for (int i = 0; i <= v.aok; i++) begin
         data_addr_ok = (i == v.aok);
         data_data_ok = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("req_req", data_req, 1);
         chk("req_stall", mem_stall, 1);
         if (i == 0) begin
            chk("req_addr", data_addr, v.addr);
            chk("req_wr", data_wr, !is_load(v.op));
            chk("req_size", data_size, $clog2(n));
            chk("req_wstrb", data_wstrb, v.exp_wstrb);
            if (!is_load(v.op)) chk("req_wdata", data_wdata, v.exp_wdata);
         end
         @(posedge clk); #1;
      end
      data_addr_ok = 1'b0;
      for (int j = 0; j <= v.dok; j++) begin
         data_data_ok = (j == v.dok);
         data_addr_ok = 1'($urandom_range(0, 1));
         data_rdata   = (j == v.dok) ? v.rdata : $urandom;
         @(negedge clk);
         chk("wait_stall", mem_stall, 1);
         chk("wait_req", data_req, 0);
         @(posedge clk); #1;
      end
      data_data_ok = 1'b0; data_addr_ok = 1'b0; data_rdata = $urandom;
      for (int h = 0; h <= v.hold; h++) begin
         @(negedge clk);
         chk("done_stall", mem_stall, 0);
         chk("done_req", data_req, 0);
         if (is_load(v.op)) chk("load_data", load_data, v.exp_load);
         if (h < v.hold) begin @(posedge clk); #1; end
      end
      if (is_load(v.op)) last_ld = v.exp_load;
      pipe_go = 1'b1;
      @(posedge clk); #1;
      pipe_go = 1'b0; mem_en = 1'b0;
   endtask

   initial begin
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
      tbl[0] = '{OP_LB,  32'h1003, 32'h0,    32'h80FF1234, 0, 0, 0, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0};
      tbl[1] = '{OP_LBU, 32'h1003, 32'h0,    32'h80FF1234, 0, 0, 0, 0, 0, 32'h00000080, 4'h0, 32'h0};
      tbl[2] = '{OP_SH,  32'h2002, 32'hBEEF, 32'h0,        1, 1, 0, 0, 0, 32'h0,        4'hC, 32'hBEEFBEEF};
      tbl[3] = '{OP_LW,  32'h3001, 32'h0,    32'h0,        0, 0, 0, 1, 0, 32'h0,        4'h0, 32'h0};
      tbl[4] = '{OP_SW,  32'h3002, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'h0,        4'h0, 32'h0};
      tbl[5] = '{OP_LH,  32'h4002, 32'h0,    32'h80017FFF, 3, 2, 0, 0, 0, 32'hFFFF8001, 4'h0, 32'h0};
      tbl[6] = '{OP_LW,  32'h1004, 32'h0,    32'h12345678, 0, 0, 3, 0, 0, 32'h12345678, 4'h0, 32'h0};
      tbl[7] = '{OP_SB,  32'h7001, 32'hA5,   32'h0,        0, 0, 0, 0, 0, 32'h0,        4'h2, 32'hA5A5A5A5};
      tbl[8] = '{OP_LHU, 32'h4000, 32'h0,    32'h80017FFF, 0, 0, 0, 0, 0, 32'h00007FFF, 4'h0, 32'h0};
      tbl[9] = '{OP_LH,  32'h4001, 32'h0,    32'h0,        0, 0, 0, 1, 0, 32'h0,        4'h0, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req", data_req, 0);
      chk("rst_wr", data_wr, 0);
      chk("rst_size", data_size, 0);
      chk("rst_addr", data_addr, 0);
      chk("rst_wdata", data_wdata, 0);
      chk("rst_wstrb", data_wstrb, 0);
      chk("rst_load", load_data, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_adel", adel, 0);
      chk("rst_bad", bad_addr, 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) do_access(tbl[i]);

      // Flush while waiting for data: bus completes, result dropped, no DONE
      mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h5000;
      @(negedge clk); chk("fl_c0_stall", mem_stall, 1);
      @(posedge clk); #1; data_addr_ok = 1'b1;
      @(negedge clk); chk("fl_req", data_req, 1);
      @(posedge clk); #1; data_addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk); chk("fl_wait_stall", mem_stall, 1);
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk); chk("fl_wait_stall2", mem_stall, 1);
      @(posedge clk); #1; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      @(negedge clk); chk("fl_dok_stall", mem_stall, 1);
      @(posedge clk); #1; data_data_ok = 1'b0; mem_en = 1'b0;
      @(negedge clk);
      chk("fl_after_stall", mem_stall, 0);
      chk("fl_after_req", data_req, 0);
      chk("fl_load_kept", load_data, last_ld);
      @(posedge clk); #1;
      do_access(model(OP_LW, 32'h5004, 32'h0, 32'hCAFEF00D, 0, 0, 0));

      // Flush in IDLE: no request that cycle
      mem_en = 1'b1; mem_op = OP_LW; mem_addr = 32'h6000; flush = 1'b1;
      @(negedge clk); chk("fli_stall", mem_stall, 0);
      @(posedge clk); #1; flush = 1'b0; mem_en = 1'b0;
      @(negedge clk); chk("fli_req", data_req, 0);
      @(posedge clk); #1;

      // Randomized accesses, including misaligned ones
      for (int r = 0; r < 40; r++) begin
         logic [7:0]  op;
         logic [31:0] a;
         op = ops[$urandom_range(0, 7)];
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(op)) - 32'd1);
         do_access(model(op, a, $urandom, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

MEM-stage data-memory access controller for the MIPS core. Checks load/store alignment, sequences a single SRAM-like transaction (req/addr_ok/data_ok) toward the AXI bridge, and stalls the pipeline until it completes. Loaded bytes and halfwords are extracted and extended, store byte strobes are generated, and an access cancelled by an exception flush is drained safely.

## Interface
- Parameters: none.
- clk  in  1  core clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_en  in  1  MEM stage holds a valid load/store.
- mem_op  in  8  alucontrol code, one of `EXE_LB_OP/LBU/LH/LHU/LW/SB/SH/SW_OP` from defines.vh; other codes mean no access.
- mem_addr  in  32  effective address; held stable while mem_stall=1.
- mem_wdata  in  32  store source (rt).
- flush  in  1  exception/eret flush of MEM stage.
- pipe_go  in  1  MEM stage advances at this edge.
- mem_stall  out  1  hold pipeline.
- load_data  out  32  formatted load result, valid in DONE.
- adel / ades  out  1  load / store address-error exception.
- bad_addr  out  32  faulting address (= mem_addr).
- data_req, data_wr  out  1  request, write flag.
- data_size  out  2  0=byte, 1=half, 2=word.
- data_addr, data_wdata  out  32  request address, replicated store data.
- data_wstrb  out  4  byte-write strobes (0 for loads).
- data_addr_ok, data_data_ok  in  1  address accepted / data returned (or write done).
- data_rdata  in  32  read data, valid with data_ok.

## Operation
- Alignment (combinational, IDLE only): LH/LHU addr[0]≠0 → adel; LW addr[1:0]≠0 → adel; SH addr[0]≠0 → ades; SW addr[1:0]≠0 → ades. Requires mem_en. On fault: no request, mem_stall=0, bad_addr=mem_addr.
- Store encode: SB wstrb=4'b0001<<addr[1:0], wdata={4{b}}; SH wstrb=0011 (addr[1]=0) / 1100, wdata={2{h}}; SW 1111.
- Request fields registered on IDLE→REQ: addr, wr, size, wstrb, wdata, op, addr[1:0].
- Load format from captured rdata using registered addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; lane = byte addr[1:0], half addr[1].
- FSM:
  - IDLE: mem_en & legal op & no fault & !flush → REQ.
  - REQ: data_req=1; on addr_ok → WAIT. req held until addr_ok, never withdrawn.
  - WAIT: on data_ok → capture rdata, DONE (or IDLE if cancelled).
  - DONE: load_data valid, mem_stall=0; pipe_go or flush → IDLE.
- cancel flag: set by flush in REQ or WAIT; transaction finishes on bus, data discarded, FSM → IDLE at data_ok; cleared there.
- mem_stall = (IDLE & mem_en & legal & !fault & !flush) | REQ | WAIT.
- data_ok outside WAIT ignored; addr_ok outside REQ ignored.

## Timing
- Reset: state=IDLE, cancel=0, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, load_data=0; adel/ades/bad_addr follow inputs (0 when mem_en=0).
- Min latency, addr_ok at first REQ cycle, data_ok next: C0 IDLE (stall=1), C1 REQ (req=1, addr_ok), C2 WAIT (data_ok), C3 DONE (stall=0, load_data valid). Each addr_ok/data_ok wait cycle adds one.
- One outstanding transaction max; next access starts no earlier than cycle after DONE→IDLE.
- Flush in IDLE: no request issued that cycle. Flush in DONE: result dropped, → IDLE.
- Reset mid-transaction: immediate IDLE, req low; bus bridge is reset by the same resetn.

## Test plan
- LB @0x1003, rdata=0x80FF_1234, addr_ok C1, data_ok C2 → DONE C3, load_data=0xFFFF_FF80, stall 1 for C0–C2; LBU same → 0x0000_0080.
- SH @0x2002, wdata=0x0000_BEEF → req=1, wr=1, size=1, wstrb=1100, data_wdata=0xBEEF_BEEF, addr=0x2002; stall until data_ok.
- LW @0x3001 → adel=1, bad_addr=0x3001, data_req never rises, stall=0; SW @0x3002 → ades=1.
- LH @0x4002 with addr_ok delayed 3 cycles and data_ok 2 more, rdata=0x8001_7FFF → req held 4 cycles, load_data=0xFFFF_8001 in DONE.
- Flush during WAIT of LW → stall stays 1 until data_ok, then IDLE with no DONE; next LW issues normally.
- DONE with pipe_go=0 for 3 cycles → remains DONE, load_data stable, no new req; pipe_go=1 → IDLE.
